// File: rtl/pll_pkg.sv
// Shared definitions for the PLL supervisor.
//   pll_state_e        : supervisor FSM states
//   *_DEFAULT          : default iCE40 PLL divider / loop-filter settings
//   max3()             : helper for sizing the shared state cycle counter
package pll_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLL_RST   = 3'd1,
    WAIT_LOCK = 3'd2,
    STABILISE = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } pll_state_e;

  localparam logic [3:0] DIVR_DEFAULT         = 4'b0000;
  localparam logic [6:0] DIVF_DEFAULT         = 7'b1000010;
  localparam logic [2:0] DIVQ_DEFAULT         = 3'b011;
  localparam logic [2:0] FILTER_RANGE_DEFAULT = 3'b001;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_ice40_core.sv
// Wrapper around the iCE40 SB_PLL40_CORE primitive.
// In synthesis the vendor primitive is used; otherwise a behavioural model
// asserts LOCK LOCK_DELAY reference cycles after RESETB rises and passes the
// reference clock straight through as the output clock.
// Ports:
//   REFERENCECLK : reference clock in
//   RESETB       : active-low PLL reset
//   LOCK         : raw (asynchronous) PLL lock indication
//   PLLOUTCORE   : PLL core output clock
module pll_ice40_core
  import pll_pkg::*;
#(
  parameter logic [3:0] DIVR         = DIVR_DEFAULT,
  parameter logic [6:0] DIVF         = DIVF_DEFAULT,
  parameter logic [2:0] DIVQ         = DIVQ_DEFAULT,
  parameter logic [2:0] FILTER_RANGE = FILTER_RANGE_DEFAULT,
  parameter int         LOCK_DELAY   = 10
) (
  input  logic REFERENCECLK,
  input  logic RESETB,
  output logic LOCK,
  output logic PLLOUTCORE
);

`ifdef SYNTHESIS
  SB_PLL40_CORE #(
    .FEEDBACK_PATH("SIMPLE"),
    .DIVR         (DIVR),
    .DIVF         (DIVF),
    .DIVQ         (DIVQ),
    .FILTER_RANGE (FILTER_RANGE)
  ) u_sb_pll (
    .REFERENCECLK   (REFERENCECLK),
    .PLLOUTCORE     (PLLOUTCORE),
    .PLLOUTGLOBAL   (),
    .EXTFEEDBACK    (1'b0),
    .DYNAMICDELAY   (8'h00),
    .LOCK           (LOCK),
    .BYPASS         (1'b0),
    .RESETB         (RESETB),
    .LATCHINPUTVALUE(1'b0),
    .SDO            (),
    .SDI            (1'b0),
    .SCLK           (1'b0)
  );
`else
  localparam int DLY_W = $clog2(LOCK_DELAY + 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(LOCK_DELAY);

  // The divider settings have no effect on the behavioural model.
  logic cfg_unused;
  assign cfg_unused = ^{DIVR, DIVF, DIVQ, FILTER_RANGE};

  logic [DLY_W-1:0] lock_dly;

  always_ff @(posedge REFERENCECLK or negedge RESETB) begin
    if (!RESETB) begin
      lock_dly <= '0;
    end else if (lock_dly != DLY_LAST) begin
      lock_dly <= lock_dly + DLY_W'(1);
    end
  end

  assign LOCK       = (lock_dly == DLY_LAST);
  assign PLLOUTCORE = REFERENCECLK;
`endif

endmodule

// File: rtl/pll_supervisor.sv
// PLL bring-up supervisor: resets the PLL, waits for lock with a per-attempt
// timeout and bounded retries, requires a stable lock window before
// releasing the downstream reset, and re-runs bring-up on lock loss.
// Ports:
//   clock_in    : reference clock, clocks all supervisor logic
//   reset       : asynchronous active-high reset
//   enable      : 1 = bring the PLL up and keep it running
//   clock_out   : PLL core output clock (direct, ungated)
//   locked      : filtered lock, high only in RUN
//   rst_out     : active-high downstream reset, low only in RUN
//   fault       : high only in FAULT (sticky until enable drops)
//   retry_count : timeouts seen in the current bring-up
//   loss_count  : saturating count of lock losses while running
module pll_supervisor
  import pll_pkg::*;
#(
  parameter logic [3:0] DIVR           = DIVR_DEFAULT,
  parameter logic [6:0] DIVF           = DIVF_DEFAULT,
  parameter logic [2:0] DIVQ           = DIVQ_DEFAULT,
  parameter logic [2:0] FILTER_RANGE   = FILTER_RANGE_DEFAULT,
  parameter int         RST_CYCLES     = 16,
  parameter int         STABLE_CYCLES  = 1024,
  parameter int         TIMEOUT_CYCLES = 65536,
  parameter int         MAX_RETRIES    = 3
) (
  input  logic                               clock_in,
  input  logic                               reset,
  input  logic                               enable,
  output logic                               clock_out,
  output logic                               locked,
  output logic                               rst_out,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
  output logic [7:0]                         loss_count
);

  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
  localparam int CNT_W   = $clog2(max3(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES)) + 1;

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  logic pll_resetb;
  logic pll_lock;

  pll_ice40_core #(
    .DIVR        (DIVR),
    .DIVF        (DIVF),
    .DIVQ        (DIVQ),
    .FILTER_RANGE(FILTER_RANGE)
  ) u_pll_core (
    .REFERENCECLK(clock_in),
    .RESETB      (pll_resetb),
    .LOCK        (pll_lock),
    .PLLOUTCORE  (clock_out)
  );

  // Stage p0/p1: two-flop synchroniser for the raw PLL lock.
  logic lock_meta_p0;
  logic lock_sync_p1;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      lock_meta_p0 <= 1'b0;
      lock_sync_p1 <= 1'b0;
    end else begin
      lock_meta_p0 <= pll_lock;
      lock_sync_p1 <= lock_meta_p0;
    end
  end

  pll_state_e           state;
  pll_state_e           state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [RETRY_W-1:0]   retry_nxt;
  logic [7:0]           loss_nxt;

  // Lock is tested before the timeout so a coincident lock wins.
  always_comb begin
    state_nxt = state;
    retry_nxt = retry_count;
    loss_nxt  = loss_count;
    if (!enable) begin
      state_nxt = IDLE;
      retry_nxt = '0;
    end else begin
      case (state)
        IDLE:      state_nxt = PLL_RST;
        PLL_RST:   if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_sync_p1) begin
            state_nxt = STABILISE;
          end else if (cnt == TIMEOUT_LAST) begin
            if (retry_count < RETRY_MAX) begin
              state_nxt = PLL_RST;
              retry_nxt = retry_count + RETRY_W'(1);
            end else begin
              state_nxt = FAULT;
            end
          end
        end
        STABILISE: begin
          if (!lock_sync_p1)             state_nxt = WAIT_LOCK;
          else if (cnt == STABLE_LAST)   state_nxt = RUN;
        end
        RUN: begin
          if (!lock_sync_p1) begin
            state_nxt = PLL_RST;
            retry_nxt = '0;
            if (loss_count != 8'hFF) loss_nxt = loss_count + 8'd1;
          end
        end
        FAULT:     state_nxt = FAULT;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they switch on the same
  // edge that enters or leaves the state they describe.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      retry_count <= '0;
      loss_count  <= '0;
      pll_resetb  <= 1'b0;
      locked      <= 1'b0;
      rst_out     <= 1'b1;
      fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
      retry_count <= retry_nxt;
      loss_count  <= loss_nxt;
      pll_resetb  <= (state_nxt == WAIT_LOCK) || (state_nxt == STABILISE) ||
                     (state_nxt == RUN);
      locked      <= (state_nxt == RUN);
      rst_out     <= (state_nxt != RUN);
      fault       <= (state_nxt == FAULT);
    end
  end

endmodule

// File: tb/tb_pll_supervisor.sv
// Bench for pll_supervisor. Raw PLL lock is driven by overriding the
// supervisor's lock net; a duration-based model of the supervisor predicts
// every output each cycle.
module tb_pll_supervisor;

  localparam int RST_CYC = 4;
  localparam int STB_CYC = 8;
  localparam int TMO_CYC = 32;
  localparam int MAX_RTY = 2;
  localparam int RW      = $clog2(MAX_RTY + 1);

  localparam int M_IDLE = 0;
  localparam int M_PRST = 1;
  localparam int M_WAIT = 2;
  localparam int M_STAB = 3;
  localparam int M_RUN  = 4;
  localparam int M_FLT  = 5;

  logic          clock_in = 1'b0;
  logic          reset;
  logic          enable;
  logic          clock_out;
  logic          locked;
  logic          rst_out;
  logic          fault;
  logic [RW-1:0] retry_count;
  logic [7:0]    loss_count;

  int n_vec    = 0;
  int n_miscmp = 0;

  // model state: phase, cycles completed in phase, counters, sync pipeline
  int m_st, m_age, m_retry, m_loss, m_s1, m_s2;
  // PLL stimulus: cycles since RESETB rose, lock delay for this attempt
  int hi_cnt, pll_n, edges;
  logic last_raw;

  pll_supervisor #(
    .RST_CYCLES    (RST_CYC),
    .STABLE_CYCLES (STB_CYC),
    .TIMEOUT_CYCLES(TMO_CYC),
    .MAX_RETRIES   (MAX_RTY)
  ) dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .enable     (enable),
    .clock_out  (clock_out),
    .locked     (locked),
    .rst_out    (rst_out),
    .fault      (fault),
    .retry_count(retry_count),
    .loss_count (loss_count)
  );

  always #5 clock_in = ~clock_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_resetb();
    return (m_st == M_WAIT) || (m_st == M_STAB) || (m_st == M_RUN);
  endfunction

  function automatic logic [31:0] model_outs();
    return 32'({m_resetb(), m_st == M_RUN, m_st != M_RUN, m_st == M_FLT,
                RW'(m_retry), 8'(m_loss)});
  endfunction

  function automatic logic [31:0] dut_outs();
    return 32'({dut.pll_resetb, locked, rst_out, fault, retry_count, loss_count});
  endfunction

  function automatic void m_go(input int s);
    m_st  = s;
    m_age = 0;
  endfunction

  function automatic void m_reset();
    m_go(M_IDLE);
    m_retry = 0;
    m_loss  = 0;
    m_s1    = 0;
    m_s2    = 0;
    hi_cnt  = 0;
  endfunction

  // One clock edge of the supervisor, described by how long each phase lasts.
  function automatic void m_step(input logic en, input logic raw);
    int lk;
    lk   = m_s2;
    m_s2 = m_s1;
    m_s1 = int'(raw);
    m_age++;
    if (!en) begin
      m_go(M_IDLE);
      m_retry = 0;
    end else begin
      case (m_st)
        M_IDLE: m_go(M_PRST);
        M_PRST: if (m_age == RST_CYC) m_go(M_WAIT);
        M_WAIT: begin
          if (lk != 0) m_go(M_STAB);
          else if (m_age == TMO_CYC) begin
            if (m_retry < MAX_RTY) begin
              m_retry++;
              m_go(M_PRST);
            end else begin
              m_go(M_FLT);
            end
          end
        end
        M_STAB: begin
          if (lk == 0) m_go(M_WAIT);
          else if (m_age == STB_CYC) m_go(M_RUN);
        end
        M_RUN: begin
          if (lk == 0) begin
            m_go(M_PRST);
            m_retry = 0;
            if (m_loss < 255) m_loss++;
          end
        end
        default: ;
      endcase
    end
  endfunction

  // Behavioural PLL: lock pll_n cycles after RESETB rises, optional 1-cycle drop.
  function automatic logic pll_raw(input logic glitch);
    if (m_resetb()) hi_cnt++;
    else hi_cnt = 0;
    return (hi_cnt != 0) && (hi_cnt >= pll_n) && !glitch;
  endfunction

  task automatic set_lock(input logic v);
    if (v) force dut.pll_lock = 1'b1;
    else   force dut.pll_lock = 1'b0;
  endtask

  task automatic tick(input logic en, input logic glitch);
    logic raw;
    raw      = pll_raw(glitch);
    enable   = en;
    set_lock(raw);
    last_raw = raw;
    m_step(en, raw);
    @(posedge clock_in);
    edges++;
    @(negedge clock_in);
    #1;
    check_eq("outputs", dut_outs(), model_outs());
    check_eq("clock_out", 32'(clock_out), 32'(clock_in));
  endtask

  task automatic async_reset(input string tag);
    #1 reset = 1'b1;
    set_lock(1'b0);
    m_reset();
    #1 check_eq(tag, dut_outs(), model_outs());
    @(posedge clock_in);
    @(negedge clock_in);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    pll_n    = 1000;
    edges    = 0;
    last_raw = 1'b0;
    m_reset();
    set_lock(1'b0);
    repeat (2) @(negedge clock_in);
    #1 check_eq("reset_state", dut_outs(), model_outs());
    reset = 1'b0;
    tick(1'b0, 1'b0);

    begin : bring_up
      int low, raw_edge, lk_edge;
      bit seen_hi;
      low = 0; raw_edge = -1; lk_edge = -1; seen_hi = 0;
      pll_n = 10;
      for (int i = 0; i < 40; i++) begin
        tick(1'b1, 1'b0);
        if (!seen_hi) begin
          if (dut.pll_resetb) seen_hi = 1;
          else low++;
        end
        if (raw_edge < 0 && last_raw) raw_edge = edges;
        if (lk_edge < 0 && locked) lk_edge = edges;
      end
      check_eq("resetb_low_cycles", 32'(low), 32'(RST_CYC));
      check_eq("lock_to_locked", 32'(lk_edge - raw_edge), 32'(2 + STB_CYC));
    end

    begin : glitch_stab
      int g_edge, lk_edge;
      bit done, g;
      g_edge = -1; lk_edge = -1; done = 0;
      tick(1'b0, 1'b0);
      pll_n = 3;
      for (int i = 0; i < 60; i++) begin
        g = !done && (m_st == M_STAB) && (m_age == 2);
        tick(1'b1, g);
        if (g) begin
          done   = 1;
          g_edge = edges;
        end
        if (done && lk_edge < 0 && locked) lk_edge = edges;
      end
      check_eq("glitch_relock_delay", 32'(lk_edge - g_edge), 32'(3 + STB_CYC));
    end

    begin : never_lock
      int n, rseq;
      logic [RW-1:0] last_r;
      n = 0; rseq = 0; last_r = '0;
      tick(1'b0, 1'b0);
      pll_n = 1000;
      while (!fault && n < 200) begin
        tick(1'b1, 1'b0);
        n++;
        if (retry_count != last_r) begin
          rseq   = rseq * 16 + int'(retry_count);
          last_r = retry_count;
        end
      end
      check_eq("cycles_to_fault", 32'(n), 32'(1 + (MAX_RTY + 1) * (RST_CYC + TMO_CYC)));
      check_eq("retry_sequence", 32'(rseq), 32'h12);
      check_eq("fault_outputs", 32'({fault, rst_out, locked}), 32'(3'b110));
      repeat (5) tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      check_eq("fault_cleared", 32'({fault, retry_count}), 32'(0));
    end

    begin : coincide
      pll_n = TMO_CYC - 1;
      for (int i = 0; i < 120; i++) begin
        if (m_retry == 1) pll_n = TMO_CYC - 2;
        tick(1'b1, 1'b0);
      end
      check_eq("coincide_lock_wins", 32'({locked, retry_count}), 32'({1'b1, RW'(1)}));
    end

    begin : loss_run
      int g_cnt, falls, cool;
      bit g;
      logic prev_locked;
      g_cnt = 0; falls = 0; cool = 0; prev_locked = locked;
      pll_n = 1;
      for (int i = 0; i < 20000 && g_cnt < 300; i++) begin
        g = (m_st == M_RUN) && (cool == 0) && ($urandom_range(0, 2) == 0);
        if (g) begin
          g_cnt++;
          cool = 4;
        end else if (cool > 0) begin
          cool--;
        end
        tick(1'b1, g);
        if (prev_locked && !locked) falls++;
        prev_locked = locked;
      end
      repeat (6) begin
        tick(1'b1, 1'b0);
        if (prev_locked && !locked) falls++;
        prev_locked = locked;
      end
      check_eq("loss_events", 32'(falls), 32'(300));
      check_eq("loss_saturated", 32'(loss_count), 32'(255));
    end

    begin : reset_mid
      tick(1'b0, 1'b0);
      pll_n = 2;
      for (int i = 0; i < 40 && !(m_st == M_STAB && m_age == 3); i++) tick(1'b1, 1'b0);
      async_reset("reset_mid_stab");
      tick(1'b0, 1'b0);
      for (int i = 0; i < 60 && m_st != M_RUN; i++) tick(1'b1, 1'b0);
      repeat (3) tick(1'b1, 1'b0);
      async_reset("reset_mid_run");
      tick(1'b0, 1'b0);
      repeat (3) tick(1'b1, 1'b0);
    end

    begin : random_run
      bit en, g;
      for (int i = 0; i < 4000; i++) begin
        if (!m_resetb()) pll_n = $urandom_range(1, 40);
        en = ($urandom_range(0, 199) != 0);
        g  = ($urandom_range(0, 23) == 0);
        tick(en, g);
        if ($urandom_range(0, 599) == 0) async_reset("reset_random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/pll_supervisor.md
PLL_SUPERVISOR -- requirements
Module: pll_supervisor

Interface
REQ-001 SHALL have parameter DIVR, default 4'b0000, PLL reference divider.
REQ-002 SHALL have parameter DIVF, default 7'b1000010, PLL feedback divider.
REQ-003 SHALL have parameter DIVQ, default 3'b011, PLL output divider.
REQ-004 SHALL have parameter FILTER_RANGE, default 3'b001, PLL loop filter range.
REQ-005 SHALL have parameter RST_CYCLES, default 16, PLL RESETB low-hold length in clock_in cycles.
REQ-006 SHALL have parameter STABLE_CYCLES, default 1024, consecutive lock cycles required before release.
REQ-007 SHALL have parameter TIMEOUT_CYCLES, default 65536, lock-wait limit per attempt.
REQ-008 SHALL have parameter MAX_RETRIES, default 3, re-attempts after first timeout before fault.
REQ-009 SHALL have port clock_in  input  1  reference clock; sole clock of all supervisor logic.
REQ-010 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-011 SHALL have port enable  input  1  1 = bring PLL up and keep it running.
REQ-012 SHALL have port clock_out  output  1  PLL core output clock.
REQ-013 SHALL have port locked  output  1  filtered lock; high only in RUN.
REQ-014 SHALL have port rst_out  output  1  active-high downstream reset; low only in RUN.
REQ-015 SHALL have port fault  output  1  high only in FAULT.
REQ-016 SHALL have port retry_count  output  $clog2(MAX_RETRIES+1)  timeouts in current bring-up.
REQ-017 SHALL have port loss_count  output  8  saturating count of lock losses in RUN.

Function
REQ-018 Raw PLL LOCK SHALL pass a 2-flop synchroniser in the clock_in domain; "lock" below means synchronised lock.
REQ-019 FSM states SHALL be IDLE, PLL_RST, WAIT_LOCK, STABILISE, RUN, FAULT.
REQ-020 IDLE: PLL RESETB=0; enable=1 -> PLL_RST next cycle.
REQ-021 PLL_RST: RESETB=0 for exactly RST_CYCLES cycles, then WAIT_LOCK.
REQ-022 WAIT_LOCK: RESETB=1; lock=1 -> STABILISE; timer reaches TIMEOUT_CYCLES with lock=0 -> PLL_RST with retry_count+1 if retry_count<MAX_RETRIES, else FAULT.
REQ-023 Lock and timeout on the same cycle SHALL resolve as lock (-> STABILISE).
REQ-024 STABILISE: lock high STABLE_CYCLES consecutive cycles -> RUN; any lock=0 -> WAIT_LOCK with timeout timer restarted from 0.
REQ-025 RUN: locked=1, rst_out=0; lock=0 -> PLL_RST, loss_count+1 (saturates at 255), retry_count cleared.
REQ-026 FAULT: sticky; RESETB=0; exits only via enable=0 -> IDLE.
REQ-027 enable=0 in any state SHALL force IDLE next cycle, overriding all other transitions; retry_count cleared, loss_count kept.
REQ-028 locked, rst_out, fault SHALL be registered, changing on the clock edge that enters/leaves the relevant state.
REQ-029 Each state's cycle counter SHALL clear on state entry; width $clog2 of largest of RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES, plus 1.
REQ-030 clock_out SHALL be PLL output directly, unregistered and ungated.

Reset
REQ-031 reset=1 SHALL asynchronously force IDLE, RESETB=0, locked=0, rst_out=1, fault=0, retry_count=0, loss_count=0, synchroniser flops=0.
REQ-032 Reset mid-operation SHALL abandon the bring-up; restart only after reset falls and enable=1.

Structure
REQ-033 State encoding and default divider constants SHALL live in shared package pll_pkg.
REQ-034 PLL primitive SHALL be instantiated in sub-module pll_ice40_core (parameters DIVR/DIVF/DIVQ/FILTER_RANGE; ports REFERENCECLK, RESETB, LOCK, PLLOUTCORE), replaceable by a behavioural model in simulation.

Verification
(RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32, MAX_RETRIES=2; model asserts LOCK N cycles after RESETB rises.)
REQ-035 Bring-up, N=10: enable=1 -> RESETB low 4 cycles; locked=1, rst_out=0 exactly 2+8 cycles after raw LOCK rises.
REQ-036 Glitch, LOCK drops for 1 cycle at cycle 5 of STABILISE -> return to WAIT_LOCK; RUN entered only after a fresh 8-cycle run of lock.
REQ-037 Never-lock -> 3 attempts of 32 cycles, retry_count 0->1->2, then fault=1, rst_out=1; enable=0 -> IDLE, fault=0.
REQ-038 Loss in RUN, 300 times -> 300 PLL_RST re-entries; loss_count saturates at 255; locked falls the cycle after synchronised LOCK falls.
REQ-039 reset asserted mid-STABILISE and mid-RUN -> outputs at reset values immediately, without a clock edge.
REQ-040 Timeout and lock coincide on cycle 32 -> STABILISE entered, retry_count unchanged.
